// File: rtl/arm_fetch_pkg.sv
// rtl/arm_fetch_pkg.sv - shared types for the instruction fetch unit
package arm_fetch_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetched {pc, instruction} entries
module fetch_queue
  import arm_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Flush wins over both push and pop; a push into a full queue is allowed only alongside a pop.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Entry storage, written at the tail pointer.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetches instruction words for the PC and queues them for decode
module instruction_fetch_unit
  import arm_fetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] instruction_address,
  input  logic              branch_taken,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instruction_valid,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] instruction_pc,
  output logic [ADDR_W-1:0] link_value,
  input  logic              instruction_ready,
  output logic              halt_temporarily_signal
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              capture;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_after;
  logic              queue_full;
  logic              queue_empty;

  assign mem_req  = (state_q == REQ);
  assign mem_addr = mem_req ? instruction_address : '0;

  // A response is kept only if it was not orphaned by an earlier branch and no branch flushes now.
  assign capture = (state_q == WAIT) & mem_rvalid & ~drop_q & ~branch_taken;
  assign pop     = instruction_valid & instruction_ready & ~branch_taken;

  assign push_entry.pc    = WORD_W'(addr_q);
  assign push_entry.instr = WORD_W'(mem_rdata);

  // The PC may move only when a word is captured or a branch redirects it.
  assign halt_temporarily_signal = reset | ~(capture | branch_taken);

  assign instruction_valid = ~queue_empty;
  assign instruction       = instruction_valid ? DATA_W'(head.instr) : '0;
  assign instruction_pc    = instruction_valid ? ADDR_W'(head.pc) : '0;
  assign link_value        = instruction_valid ? instruction_pc + ADDR_W'(1) : '0;

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (capture),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (branch_taken),
    .head       (head),
    .count      (count),
    .full       (queue_full),
    .empty      (queue_empty)
  );

  // Queue occupancy after this edge, used to decide whether another fetch fits.
  always_comb begin
    count_after = count;
    if (branch_taken) begin
      count_after = '0;
    end else begin
      unique case ({capture, pop})
        2'b10:   count_after = count + CNT_W'(1);
        2'b01:   count_after = count - CNT_W'(1);
        default: count_after = count;
      endcase
    end
  end

  // Next-state logic: one outstanding fetch, a branch orphans any in-flight response.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (branch_taken | ~queue_full | pop) state_d = REQ;
      end
      REQ: begin
        if (mem_gnt) begin
          state_d = WAIT;
          addr_d  = instruction_address;
          drop_d  = branch_taken;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          drop_d  = 1'b0;
          state_d = (count_after < CNT_W'(DEPTH)) ? REQ : IDLE;
        end else if (branch_taken) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, drop flag and granted address registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] link;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [31:0] instruction_address;
  logic        branch_taken;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instruction_valid;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;
  logic [31:0] link_value;
  logic        instruction_ready;
  logic        halt_temporarily_signal;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  int          grants_left = 0;
  int          lat = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  bit          ready_en = 0;
  bit          release_now = 0;
  int          halt_lows = 0;

  instruction_fetch_unit #(
    .DEPTH(4),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .instruction_address     (instruction_address),
    .branch_taken            (branch_taken),
    .mem_req                 (mem_req),
    .mem_addr                (mem_addr),
    .mem_gnt                 (mem_gnt),
    .mem_rvalid              (mem_rvalid),
    .mem_rdata               (mem_rdata),
    .instruction_valid       (instruction_valid),
    .instruction             (instruction),
    .instruction_pc          (instruction_pc),
    .link_value              (link_value),
    .instruction_ready       (instruction_ready),
    .halt_temporarily_signal (halt_temporarily_signal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] link);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    e.link = link;
    exp_q.push_back(e);
  endtask

  // One clock cycle: drive inputs after posedge, model the PC and memory at negedge.
  task automatic step(input logic br, input logic [31:0] tgt);
    @(posedge clock);
    #1;
    if (release_now) begin
      reset = 1'b0;
      release_now = 0;
    end
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = ~pend_addr;
      end
    end
    branch_taken      = br;
    instruction_ready = ready_en;
    mem_gnt           = mem_req && (grants_left > 0);
    @(negedge clock);
    #1;
    if (!halt_temporarily_signal) begin
      halt_lows++;
      instruction_address = br ? tgt : instruction_address + 32'd1;
    end
    if (mem_req && mem_gnt) begin
      grants_left--;
      pend_addr = instruction_address;
      pend_cnt  = lat;
    end
  endtask

  task automatic run_until_empty(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step(1'b0, '0);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: every accepted head must match the oldest expected entry.
  always @(negedge clock) begin
    if (!reset && instruction_valid && instruction_ready && !branch_taken) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pop: got pc %h, expected no instruction", instruction_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_pc", instruction_pc, mon_e.pc);
        chk("pop_instr", instruction, mon_e.instr);
        chk("pop_link", link_value, mon_e.link);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    instruction_address = '0;
    branch_taken = 1'b0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    instruction_ready = 1'b0;

    // Reset values
    repeat (3) step(1'b0, '0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_valid", instruction_valid, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_pc", instruction_pc, 0);
    chk("rst_link", link_value, 0);
    chk("rst_halt", halt_temporarily_signal, 1);

    // 1: streaming fetch of pc 0,1,2
    grants_left = 3; lat = 1; ready_en = 1; halt_lows = 0;
    push_exp(32'h0, 32'hFFFF_FFFF, 32'h1);
    push_exp(32'h1, 32'hFFFF_FFFE, 32'h2);
    push_exp(32'h2, 32'hFFFF_FFFD, 32'h3);
    reset = 1'b0;
    run_until_empty(40);
    chk("t1_halt_lows", halt_lows, 3);
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h3);
    chk("t1_halt", halt_temporarily_signal, 1);

    // 2: decode stalled, queue fills, then one pop restarts fetching
    ready_en = 0; grants_left = 4; halt_lows = 0;
    push_exp(32'h3, 32'hFFFF_FFFC, 32'h4);
    push_exp(32'h4, 32'hFFFF_FFFB, 32'h5);
    push_exp(32'h5, 32'hFFFF_FFFA, 32'h6);
    push_exp(32'h6, 32'hFFFF_FFF9, 32'h7);
    repeat (16) step(1'b0, '0);
    chk("t2_halt_lows", halt_lows, 4);
    chk("t2_mem_req_full", mem_req, 0);
    chk("t2_valid", instruction_valid, 1);
    chk("t2_head_pc", instruction_pc, 32'h3);
    chk("t2_head_link", link_value, 32'h4);
    chk("t2_halt", halt_temporarily_signal, 1);
    ready_en = 1;
    step(1'b0, '0);
    ready_en = 0;
    step(1'b0, '0);
    chk("t2_mem_req_again", mem_req, 1);
    chk("t2_mem_addr", mem_addr, 32'h7);
    grants_left = 1;
    push_exp(32'h7, 32'hFFFF_FFF8, 32'h8);
    repeat (4) step(1'b0, '0);
    ready_en = 1;
    run_until_empty(40);

    // 3: branch in REQ (to 5), then branch in WAIT before rvalid (to 20)
    step(1'b1, 32'h5);
    step(1'b0, '0);
    chk("t3_req_addr5", mem_addr, 32'h5);
    chk("t3_req", mem_req, 1);
    lat = 3; grants_left = 1;
    step(1'b0, '0);
    step(1'b1, 32'h14);
    step(1'b0, '0);
    step(1'b0, '0);
    chk("t3_drop_halt", halt_temporarily_signal, 1);
    chk("t3_drop_valid", instruction_valid, 0);
    step(1'b0, '0);
    chk("t3_refetch_req", mem_req, 1);
    chk("t3_refetch_addr", mem_addr, 32'h14);
    lat = 1; grants_left = 1;
    push_exp(32'h14, 32'hFFFF_FFEB, 32'h15);
    run_until_empty(40);

    // 4: branch in the same cycle as the grant
    grants_left = 1;
    step(1'b1, 32'h28);
    step(1'b0, '0);
    chk("t4_drop_halt", halt_temporarily_signal, 1);
    chk("t4_drop_valid", instruction_valid, 0);
    step(1'b0, '0);
    chk("t4_refetch_addr", mem_addr, 32'h28);
    grants_left = 1;
    push_exp(32'h28, 32'hFFFF_FFD7, 32'h29);
    run_until_empty(40);

    // 5: reset while waiting with two entries queued
    ready_en = 0; grants_left = 2; lat = 1;
    repeat (6) step(1'b0, '0);
    chk("t5_head_pc", instruction_pc, 32'h29);
    chk("t5_head_instr", instruction, 32'hFFFF_FFD6);
    chk("t5_mem_addr", mem_addr, 32'h2B);
    lat = 5; grants_left = 1;
    step(1'b0, '0);
    step(1'b0, '0);
    chk("t5_wait_req", mem_req, 0);
    reset = 1'b1;
    #1;
    chk("t5_async_valid", instruction_valid, 0);
    chk("t5_async_instr", instruction, 0);
    chk("t5_async_pc", instruction_pc, 0);
    chk("t5_async_req", mem_req, 0);
    chk("t5_async_halt", halt_temporarily_signal, 1);
    instruction_address = '0;
    for (int i = 0; i < 10 && pend_cnt != 1; i++) step(1'b0, '0);
    release_now = 1;
    step(1'b0, '0);
    chk("t5_stray_valid", instruction_valid, 0);
    chk("t5_stray_halt", halt_temporarily_signal, 1);
    grants_left = 2; lat = 1; ready_en = 1;
    push_exp(32'h0, 32'hFFFF_FFFF, 32'h1);
    push_exp(32'h1, 32'hFFFF_FFFE, 32'h2);
    step(1'b0, '0);
    chk("t5_restart_req", mem_req, 1);
    run_until_empty(40);

    // 6: link value wraps at the top of the address space
    step(1'b1, 32'hFFFF_FFFF);
    grants_left = 1;
    push_exp(32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000);
    run_until_empty(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
